// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous 1-cycle-latency memory between the CPU (port A) and the loader (port B).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is A-priority with a MAX_BURST starvation limit.
module mem_arbiter #(
  parameter int AW        = 15,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  logic          gnt_a_s, gnt_b_s, b_wins_s, any_gnt_s, rd_ret_s;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          owner_b_q, owner_b_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
  logic          busy_q, busy_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_b_q, last_b_d;

  // Under contention the port that did not win last time goes first.
  assign b_wins_s = b_req & (~a_req | ~last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if (any_gnt_s) begin
      last_b_d = gnt_b_s;
    end else begin
      last_b_d = last_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_b_q <= 1'b1;
    else        last_b_q <= last_b_d;
  end
`else
  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);
  logic [3:0] burst_q, burst_d;

  // B is forced in once A has taken MAX_BURST grants while B was waiting.
  assign b_wins_s = b_req & (~a_req | (burst_q == MaxBurst));

  always_comb begin
    burst_d = burst_q;
    if (!b_req || gnt_b_s) begin
      burst_d = 4'd0;
    end else if (gnt_a_s) begin
      burst_d = burst_q + 4'd1;
    end else begin
      burst_d = burst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) burst_q <= 4'd0;
    else        burst_q <= burst_d;
  end
`endif

  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (rst_n) begin
      gnt_b_s = b_wins_s;
      gnt_a_s = a_req & ~b_wins_s;
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  assign any_gnt_s = gnt_a_s | gnt_b_s;
  assign rd_ret_s  = mem_en_q & ~mem_we_q;

  always_comb begin
    mem_en_d    = any_gnt_s;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_b_d   = owner_b_q;
    if (gnt_b_s) begin
      mem_we_d    = b_we;
      mem_addr_d  = b_addr;
      mem_wdata_d = b_wdata;
      owner_b_d   = 1'b1;
    end else if (gnt_a_s) begin
      mem_we_d    = a_we;
      mem_addr_d  = a_addr;
      mem_wdata_d = a_wdata;
      owner_b_d   = 1'b0;
    end else begin
      mem_we_d    = 1'b0;
    end
    a_rvalid_d = rd_ret_s & ~owner_b_q;
    b_rvalid_d = rd_ret_s & owner_b_q;
    a_hold_d   = a_rvalid_q ? mem_rdata : a_hold_q;
    b_hold_d   = b_rvalid_q ? mem_rdata : b_hold_q;
    busy_d     = any_gnt_s | rd_ret_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_b_q   <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_b_q   <= owner_b_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_hold_q    <= a_hold_d;
      b_hold_q    <= b_hold_d;
      busy_q      <= busy_d;
    end
  end

  assign a_gnt     = gnt_a_s;
  assign b_gnt     = gnt_b_s;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  // Memory data arrives in the rvalid cycle itself, so it is passed through then and held afterwards.
  assign a_rdata   = a_rvalid_q ? mem_rdata : a_hold_q;
  assign b_rdata   = b_rvalid_q ? mem_rdata : b_hold_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus arbitration, back-to-back and reset sequences.
module tb_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, a_req, a_we, b_req, b_we, a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy, mem_init;
  logic [DW-1:0] mem [0:32767];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Write-first synchronous memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 32768; k++) mem[k] <= 16'h0000;
      mem[16] <= 16'h8005;
      mem_rdata <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic rst_n; logic a_req; logic a_we; logic [14:0] a_addr; logic [15:0] a_wdata;
    logic b_req; logic b_we; logic [14:0] b_addr; logic [15:0] b_wdata;
  } in_t;
  typedef struct packed {
    logic a_gnt; logic b_gnt; logic mem_en; logic mem_we; logic [14:0] mem_addr;
    logic [15:0] mem_wdata; logic a_rvalid; logic [15:0] a_rdata;
    logic b_rvalid; logic [15:0] b_rdata; logic busy;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  int checks = 0;
  int failures = 0;

  function automatic in_t mk_in(logic r, logic ar, logic aw, logic [14:0] aa, logic [15:0] ad,
                                logic br, logic bw, logic [14:0] ba, logic [15:0] bd);
    in_t v;
    v.rst_n = r; v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    return v;
  endfunction

  function automatic out_t mk_out(logic ag, logic bg, logic en, logic we, logic [14:0] ad,
                                  logic [15:0] wd, logic arv, logic [15:0] ard,
                                  logic brv, logic [15:0] brd, logic bz);
    out_t v;
    v.a_gnt = ag; v.b_gnt = bg; v.mem_en = en; v.mem_we = we; v.mem_addr = ad;
    v.mem_wdata = wd; v.a_rvalid = arv; v.a_rdata = ard; v.b_rvalid = brv;
    v.b_rdata = brd; v.busy = bz;
    return v;
  endfunction

  function automatic out_t sample();
    return mk_out(a_gnt, b_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                  a_rvalid, a_rdata, b_rvalid, b_rdata, busy);
  endfunction

  task automatic apply(input in_t v);
    rst_n = v.rst_n; a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
  endtask

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(mk_in(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0));
    tick();
  endtask

  initial begin
    vec_t tbl [0:16];
    in_t  idle;
    logic exp_ga [0:9];
    logic ega, egb, erva, ervb;

    idle = mk_in(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0);
    //               rst   areq  awe   aaddr     awdata      breq  bwe   baddr    bwdata
    tbl[0].i  = mk_in(1'b0, 1'b1, 1'b0, 15'h0010, 16'h0000, 1'b0, 1'b0, 15'h0, 16'h0);
    tbl[1].i  = mk_in(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0000, 1'b0, 1'b0, 15'h0, 16'h0);
    tbl[2].i  = idle;
    tbl[3].i  = idle;
    tbl[4].i  = mk_in(1'b1, 1'b0, 1'b0, 15'h0000, 16'h0000, 1'b1, 1'b1, 15'h0003, 16'h1234);
    tbl[5].i  = mk_in(1'b1, 1'b1, 1'b0, 15'h0003, 16'h0000, 1'b0, 1'b0, 15'h0, 16'h0);
    tbl[6].i  = idle;
    tbl[7].i  = idle;
    tbl[8].i  = mk_in(1'b1, 1'b0, 1'b0, 15'h0000, 16'h0000, 1'b1, 1'b0, 15'h0010, 16'h0000);
    tbl[9].i  = idle;
    tbl[10].i = idle;
    tbl[11].i = mk_in(1'b1, 1'b1, 1'b1, 15'h0020, 16'hBEEF, 1'b0, 1'b0, 15'h0, 16'h0);
    tbl[12].i = idle;
    tbl[13].i = idle;
    tbl[14].i = mk_in(1'b1, 1'b1, 1'b0, 15'h0020, 16'h0000, 1'b0, 1'b0, 15'h0, 16'h0);
    tbl[15].i = idle;
    tbl[16].i = idle;
    //                 ag    bg    en    we    addr      wdata     arv   ardata    brv   brdata    busy
    tbl[0].o  = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tbl[1].o  = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tbl[2].o  = mk_out(1'b0, 1'b0, 1'b1, 1'b0, 15'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    tbl[3].o  = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 15'h0010, 16'h0000, 1'b1, 16'h8005, 1'b0, 16'h0000, 1'b1);
    tbl[4].o  = mk_out(1'b0, 1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000, 1'b0, 16'h8005, 1'b0, 16'h0000, 1'b0);
    tbl[5].o  = mk_out(1'b1, 1'b0, 1'b1, 1'b1, 15'h0003, 16'h1234, 1'b0, 16'h8005, 1'b0, 16'h0000, 1'b1);
    tbl[6].o  = mk_out(1'b0, 1'b0, 1'b1, 1'b0, 15'h0003, 16'h0000, 1'b0, 16'h8005, 1'b0, 16'h0000, 1'b1);
    tbl[7].o  = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 15'h0003, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1);
    tbl[8].o  = mk_out(1'b0, 1'b1, 1'b0, 1'b0, 15'h0003, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0);
    tbl[9].o  = mk_out(1'b0, 1'b0, 1'b1, 1'b0, 15'h0010, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b1);
    tbl[10].o = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 15'h0010, 16'h0000, 1'b0, 16'h1234, 1'b1, 16'h8005, 1'b1);
    tbl[11].o = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 15'h0010, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h8005, 1'b0);
    tbl[12].o = mk_out(1'b0, 1'b0, 1'b1, 1'b1, 15'h0020, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 16'h8005, 1'b1);
    tbl[13].o = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 15'h0020, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 16'h8005, 1'b0);
    tbl[14].o = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 15'h0020, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 16'h8005, 1'b0);
    tbl[15].o = mk_out(1'b0, 1'b0, 1'b1, 1'b0, 15'h0020, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h8005, 1'b1);
    tbl[16].o = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 15'h0020, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h8005, 1'b1);

    for (int k = 0; k < 10; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ga[k] = ((k % 2) == 0);
`else
      exp_ga[k] = ((k % 5) != 4);
`endif
    end

    mem_init = 1'b1;
    apply(mk_in(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0));
    tick();
    mem_init = 1'b0;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].i);
      @(negedge clk);
      chk($sformatf("row%0d", i), sample(), tbl[i].o);
      tick();
    end

    // Both ports stream reads: grant order and per-port return routing.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k < 10) apply(mk_in(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 1'b0, 15'h0003, 16'h0));
      else        apply(idle);
      @(negedge clk);
      ega  = (k < 10) ? exp_ga[k] : 1'b0;
      egb  = (k < 10) ? ~exp_ga[k] : 1'b0;
      erva = (k >= 2) ? exp_ga[k-2] : 1'b0;
      ervb = (k >= 2) ? ~exp_ga[k-2] : 1'b0;
      chk($sformatf("arb_c%0d", k), 70'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 70'({ega, egb, erva, ervb}));
      if (erva) chk($sformatf("arb_ardata_c%0d", k), 70'(a_rdata), 70'(16'h8005));
      if (ervb) chk($sformatf("arb_brdata_c%0d", k), 70'(b_rdata), 70'(16'h1234));
      tick();
    end

    // Eight back-to-back A reads with B idle.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k < 8) apply(mk_in(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0));
      else       apply(idle);
      @(negedge clk);
      chk($sformatf("b2b_c%0d", k), 70'({a_gnt, mem_en, a_rvalid, busy, b_rvalid}),
          70'({(k < 8), (k >= 1 && k <= 8), (k >= 2 && k <= 9), (k >= 1 && k <= 9), 1'b0}));
      if (k >= 2 && k <= 9) chk($sformatf("b2b_rdata_c%0d", k), 70'(a_rdata), 70'(16'h8005));
      tick();
    end

    // Reset lands while a read is in its command stage.
    do_reset();
    apply(mk_in(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0));
    @(negedge clk);
    chk("rst_mid_gnt", 70'(a_gnt), 70'(1'b1));
    tick();
    apply(mk_in(1'b0, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 1'b0, 15'h0, 16'h0));
    @(negedge clk);
    chk("rst_mid_cmd", 70'({mem_en, a_gnt, b_gnt}), 70'(3'b100));
    tick();
    apply(idle);
    @(negedge clk);
    chk("rst_mid_outputs", sample(), mk_out(1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0));
    tick();
    @(negedge clk);
    chk("rst_mid_no_rvalid", 70'({a_rvalid, b_rvalid, busy}), 70'(3'b000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit word-addressed program/data memory between two requesters.
- Port A is the stack CPU instruction/data path. Port B is the host program loader / debug monitor.
- Grants at most one access per cycle and presents a registered command to a synchronous memory with 1-cycle read latency.
- Returns read data to the port that issued the read.

Parameters:
- AW, 15, word-address width; matches the CPU's ip[15:1] word index.
- DW, 16, data width.
- MAX_BURST, 4, maximum consecutive port-A grants while b_req is pending; range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- a_req  in  1  port A request; addr/we/wdata held stable while a_req=1 and a_gnt=0.
- a_we  in  1  port A write enable (1=write, 0=read).
- a_addr  in  AW  port A word address.
- a_wdata  in  DW  port A write data.
- a_gnt  out  1  combinational; request accepted this cycle.
- a_rvalid  out  1  registered; a_rdata valid this cycle.
- a_rdata  out  DW  read data for port A.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the port A signals, for port B.
- mem_en  out  1  registered memory access strobe.
- mem_we  out  1  registered memory write enable.
- mem_addr  out  AW  registered memory address.
- mem_wdata  out  DW  registered memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.
- busy  out  1  registered; 1 while any access is in the command or read-return stage.

Behaviour:
- Reset (rst_n=0 at posedge):
  - mem_en, mem_we, a_rvalid, b_rvalid, busy all 0.
  - mem_addr, mem_wdata, a_rdata, b_rdata all 0.
  - Burst counter 0; last-grant flag = B.
  - An in-flight read is discarded; no rvalid after reset.
  - While rst_n=0, a_gnt and b_gnt are 0.
- Grant (cycle N):
  - At most one of a_gnt/b_gnt is 1.
  - A grant is issued only if the matching req=1.
  - A requester's access is accepted at the posedge ending the cycle in which its gnt=1.
- Command (cycle N+1):
  - mem_en=1; mem_we/mem_addr/mem_wdata copy the granted port's fields.
  - mem_en=0 in any cycle following a cycle with no grant.
- Read return (cycle N+2):
  - If the access was a read, the issuing port's rvalid=1 for exactly one cycle, with rdata=mem_rdata registered.
  - Writes produce no rvalid.
  - A 2-entry owner/read-tag pipe tracks the issuing port.
  - rdata holds its last value while rvalid=0.
- Throughput: back-to-back grants every cycle are legal. Port A read latency is 2 cycles from gnt.
- Arbitration, default build:
  - Fixed priority to A.
  - Burst counter increments on each A grant made while b_req=1.
  - The counter clears on any B grant, and whenever b_req=0.
  - When counter==MAX_BURST and b_req=1, B wins the next cycle even if a_req=1.
  - Only one requester present: it is granted immediately.
- No grant when both req=0; last-grant flag unchanged.
- busy = mem_en_stage OR read_return_pending.
- Write then read of the same address in consecutive grants returns the new data; the memory is write-first.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Burst counter removed; MAX_BURST ignored.
  - When both req=1, grant goes to the port opposite the last-grant flag.
  - Single requester is granted immediately.
  - Last-grant flag updates on every grant.
- Undefined: fixed priority with MAX_BURST starvation limit as above.

Test Plan:
- Reset mid-read: A read granted at cycle 5, rst_n=0 at cycle 6 → no a_rvalid at cycle 7; all outputs 0 at cycle 7.
- Single A read: mem holds 0x8005 at 0x0010; a_req=1, a_we=0, a_addr=0x0010 at cycle 0 → a_gnt=1 cycle 0; mem_en=1, mem_addr=0x0010 cycle 1; a_rvalid=1, a_rdata=0x8005 cycle 2; b_rvalid=0 throughout.
- B write then A read of same address: B writes 0x1234 to 0x0003 (gnt cycle 0); A reads 0x0003 (gnt cycle 1) → mem_we=1 cycle 1; a_rdata=0x1234 with a_rvalid at cycle 3.
- Simultaneous requests, default build, MAX_BURST=4: a_req and b_req held high with reads → grant sequence A,A,A,A,B,A,A,A,A,B,…; b_gnt first at cycle 4.
- Round-robin build: both req held high, last-grant flag=B after reset → grants A,B,A,B…; each rvalid arrives on the correct port 2 cycles after its gnt.
- Idle/back-to-back: A issues reads every cycle for 8 cycles, B idle → mem_en high for cycles 1–8, a_rvalid high for cycles 2–9, busy deasserts at cycle 10.
